// File: rtl/cle_probe_initiator_if.sv
// rtl/cle_probe_initiator_if.sv - CLE16 key-window bus pins between initiator and key PAL
interface cle_probe_initiator_if;
  logic       sser;
  logic       ba13;
  logic       ba12;
  logic [3:0] ba_nib;
  logic       br_w;
  logic       sdrd;
  logic       sdrd_alt;

  modport master (
    output sser, ba13, ba12, ba_nib, br_w,
    input  sdrd, sdrd_alt
  );

  modport slave (
    input  sser, ba13, ba12, ba_nib, br_w,
    output sdrd, sdrd_alt
  );
endinterface

// File: rtl/cle_probe_initiator.sv
// rtl/cle_probe_initiator.sv - replays nibble read strobes into the CLE16 key window and checks the response word
module cle_probe_initiator #(
  parameter int NSTEP     = 16,
  parameter int SETUP_CYC = 2,
  parameter int RECOV_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [4*NSTEP-1:0]   seq,
  input  logic [NSTEP-1:0]     expect_word,
  cle_probe_initiator_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NSTEP-1:0]     rsp
);

  localparam int SW = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RECOV,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SW-1:0]    step;
  logic [SW-1:0]    step_nxt;
  logic [3:0]       cyc;
  logic [4*NSTEP-1:0] seq_q;
  logic [NSTEP-1:0] exp_q;
  logic             phase_end;
  logic             last_step;
  logic [3:0]       nib_src;

  logic             sser_d;
  logic             ba13_d;
  logic             ba12_d;
  logic [3:0]       nib_d;
  logic             busy_d;
  logic             done_d;

  // Phase timer end: SETUP and RECOV each last a programmed number of cycles
  always_comb begin
    phase_end = 1'b0;
    last_step = (step == SW'(NSTEP - 1));
    case (state)
      S_SETUP: phase_end = (cyc == 4'(SETUP_CYC - 1));
      S_RECOV: phase_end = (cyc == 4'(RECOV_CYC - 1));
      default: phase_end = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort beats everything, including a same-cycle start
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start && !abort) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (abort)          state_nxt = S_IDLE;
        else if (phase_end) state_nxt = S_STROBE;
      end
      S_STROBE: begin
        state_nxt = abort ? S_IDLE : S_RECOV;
      end
      S_RECOV: begin
        if (abort)          state_nxt = S_IDLE;
        else if (phase_end) state_nxt = last_step ? S_DONE : S_SETUP;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Step index for the coming cycle, so the nibble can be registered together with the state
  always_comb begin
    step_nxt = step;
    if (state == S_IDLE && state_nxt == S_SETUP) begin
      step_nxt = '0;
    end else if (state == S_RECOV && state_nxt == S_SETUP) begin
      step_nxt = step + SW'(1);
    end
  end

  // Output decode from the next state; the flops below make every pin registered
  always_comb begin
    sser_d  = 1'b1;
    ba13_d  = 1'b1;
    ba12_d  = 1'b0;
    nib_d   = 4'h0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    // seq_q is not loaded yet on the start edge, so step 0 comes straight from the input
    nib_src = (state == S_IDLE) ? seq[3:0] : seq_q[{step_nxt, 2'b00} +: 4];
    case (state_nxt)
      S_SETUP, S_STROBE, S_RECOV: begin
        ba13_d = 1'b0;
        ba12_d = 1'b1;
        nib_d  = nib_src;
        busy_d = 1'b1;
        sser_d = (state_nxt != S_STROBE);
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        sser_d = 1'b1;
      end
    endcase
  end

  // Registered bus pins and status; reset parks the bus immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sser   <= 1'b1;
      bus.ba13   <= 1'b1;
      bus.ba12   <= 1'b0;
      bus.ba_nib <= 4'h0;
      bus.br_w   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      bus.sser   <= sser_d;
      bus.ba13   <= ba13_d;
      bus.ba12   <= ba12_d;
      bus.ba_nib <= nib_d;
      bus.br_w   <= 1'b1;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Run datapath: latch the program, time phases, capture the key bit at the end of STROBE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step  <= '0;
      cyc   <= 4'h0;
      seq_q <= '0;
      exp_q <= '0;
      rsp   <= '0;
      pass  <= 1'b0;
    end else begin
      step <= step_nxt;
      cyc  <= (state_nxt != state) ? 4'h0 : cyc + 4'h1;
      if (state == S_IDLE && state_nxt == S_SETUP) begin
        seq_q <= seq;
        exp_q <= expect_word;
        rsp   <= '0;
        pass  <= 1'b0;
      end
      if (state == S_STROBE && state_nxt == S_RECOV) begin
        rsp[step] <= bus.sdrd | bus.sdrd_alt;
      end
      if (state_nxt == S_DONE) begin
        pass <= (rsp == exp_q);
      end
      if (abort && state != S_IDLE) begin
        pass <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cle_probe_initiator.sv
// tb/tb_cle_probe_initiator.sv - scoreboard bench for cle_probe_initiator
module tb_cle_probe_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rsp;
    logic        pass;
    int unsigned st;
    int unsigned lat;
  } sb_t;

  sb_t        sb_a[$];
  sb_t        sb_b[$];
  logic [3:0] nib_a[$];

  // DUT A: NSTEP=4, SETUP=2, RECOV=1, responder keyed on the probe nibble via sdrd
  logic        start_a = 1'b0;
  logic        abort_a = 1'b0;
  logic [15:0] seq_a = 16'h0;
  logic [3:0]  exp_a = 4'h0;
  logic        busy_a, done_a, pass_a;
  logic [3:0]  rsp_a;
  logic [15:0] resp_map = 16'h0428;

  cle_probe_initiator_if bus_a();
  assign bus_a.sdrd     = ~bus_a.sser & resp_map[bus_a.ba_nib];
  assign bus_a.sdrd_alt = 1'b0;

  cle_probe_initiator #(.NSTEP(4), .SETUP_CYC(2), .RECOV_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .seq(seq_a), .expect_word(exp_a), .bus(bus_a.master),
    .busy(busy_a), .done(done_a), .pass(pass_a), .rsp(rsp_a)
  );

  // DUT B: NSTEP=2, minimum phase lengths, responder answers only on sdrd_alt
  logic       start_b = 1'b0;
  logic       abort_b = 1'b0;
  logic [7:0] seq_b = 8'h0;
  logic [1:0] exp_b = 2'b0;
  logic       busy_b, done_b, pass_b;
  logic [1:0] rsp_b;

  cle_probe_initiator_if bus_b();
  assign bus_b.sdrd     = 1'b0;
  assign bus_b.sdrd_alt = ~bus_b.sser;

  cle_probe_initiator #(.NSTEP(2), .SETUP_CYC(1), .RECOV_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .seq(seq_b), .expect_word(exp_b), .bus(bus_b.master),
    .busy(busy_b), .done(done_b), .pass(pass_b), .rsp(rsp_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Done monitors: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && done_a) begin
      if (sb_a.size() == 0) flag("unexpected_done_a");
      else begin
        e = sb_a.pop_front();
        chk("rsp_a", 32'(rsp_a), e.rsp);
        chk("pass_a", 32'(pass_a), 32'(e.pass));
        chk("latency_a", cyc - e.st, e.lat);
        chk("busy_at_done_a", 32'(busy_a), 32'(0));
      end
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (rst_n && done_b) begin
      if (sb_b.size() == 0) flag("unexpected_done_b");
      else begin
        e = sb_b.pop_front();
        chk("rsp_b", 32'(rsp_b), e.rsp);
        chk("pass_b", 32'(pass_b), 32'(e.pass));
        chk("latency_b", cyc - e.st, e.lat);
      end
    end
  end

  // Bus protocol monitor for DUT A
  logic       prev_sser_a = 1'b1;
  logic       prev_rstn = 1'b0;
  logic       abort_seen_a = 1'b0;
  logic [5:0] prev_addr_a = 6'h0;
  logic       prev_sser_b = 1'b1;

  always @(posedge clk) abort_seen_a <= abort_a;

  always @(negedge clk) begin
    logic [3:0] en;
    if (rst_n && prev_rstn) begin
      chk("br_w_a", 32'(bus_a.br_w), 32'(1));
      if (!bus_a.sser) begin
        chk("sser_single_a", 32'(prev_sser_a), 32'(1));
        chk("strobe_ba13_a", 32'(bus_a.ba13), 32'(0));
        chk("strobe_ba12_a", 32'(bus_a.ba12), 32'(1));
        if (nib_a.size() == 0) flag("unexpected_strobe_a");
        else begin
          en = nib_a.pop_front();
          chk("strobe_nibble_a", 32'(bus_a.ba_nib), 32'(en));
        end
      end
      if ((!bus_a.sser || !prev_sser_a) && !abort_seen_a)
        chk("addr_hold_a", 32'({bus_a.ba13, bus_a.ba12, bus_a.ba_nib}), 32'(prev_addr_a));
      if (!bus_b.sser)
        chk("sser_single_b", 32'(prev_sser_b), 32'(1));
    end
    prev_rstn   <= rst_n;
    prev_sser_a <= bus_a.sser;
    prev_sser_b <= bus_b.sser;
    prev_addr_a <= {bus_a.ba13, bus_a.ba12, bus_a.ba_nib};
  end

  task automatic push_nibs(input logic [15:0] s, input int n);
    for (int k = 0; k < n; k++) nib_a.push_back(s[4*k +: 4]);
  endtask

  task automatic start_run_a(input logic [15:0] s, input logic [3:0] e);
    @(negedge clk);
    seq_a   = s;
    exp_a   = e;
    start_a = 1'b1;
  endtask

  task automatic wait_strobe_a(input int n);
    int  cnt = 0;
    bit  ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus_a.sser) begin
        cnt++;
        if (cnt == n) begin
          ok = 1;
          break;
        end
      end
    end
    if (!ok) flag("timeout_strobe_a");
  endtask

  task automatic wait_idle_a();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_a.size() == 0 && !busy_a) begin
        ok = 1;
        break;
      end
    end
    if (!ok) flag("timeout_done_a");
  endtask

  task automatic run_a(input logic [15:0] s, input logic [3:0] e,
                       input logic [3:0] r, input logic p);
    push_nibs(s, 4);
    start_run_a(s, e);
    sb_a.push_back('{rsp: 32'(r), pass: p, st: cyc, lat: 32'd17});
    @(negedge clk);
    start_a = 1'b0;
    wait_idle_a();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sser", 32'(bus_a.sser), 32'(1));
    chk("rst_ba13", 32'(bus_a.ba13), 32'(1));
    chk("rst_ba12", 32'(bus_a.ba12), 32'(0));
    chk("rst_nib", 32'(bus_a.ba_nib), 32'(0));
    chk("rst_br_w", 32'(bus_a.br_w), 32'(1));
    chk("rst_busy", 32'(busy_a), 32'(0));
    chk("rst_done", 32'(done_a), 32'(0));
    chk("rst_pass", 32'(pass_a), 32'(0));
    chk("rst_rsp", 32'(rsp_a), 32'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted during the second STROBE: bus parks at once, no done
    push_nibs(16'h3A25, 2);
    start_run_a(16'h3A25, 4'b1101);
    @(negedge clk);
    start_a = 1'b0;
    wait_strobe_a(1);
    wait_strobe_a(1);
    chk("rsp_before_reset", 32'(rsp_a), 32'(4'b0001));
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_sser", 32'(bus_a.sser), 32'(1));
    chk("midrun_rst_busy", 32'(busy_a), 32'(0));
    chk("midrun_rst_rsp", 32'(rsp_a), 32'(0));
    chk("midrun_rst_ba13", 32'(bus_a.ba13), 32'(1));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Full runs: matching and mismatching expect, then a second probe order
    run_a(16'h3A25, 4'b1101, 4'b1101, 1'b1);
    run_a(16'h3A25, 4'b1100, 4'b1101, 1'b0);
    run_a(16'h2A53, 4'b0111, 4'b0111, 1'b1);

    // Abort on the third STROBE keeps two captured bits and clears pass
    push_nibs(16'h3A25, 3);
    start_run_a(16'h3A25, 4'b1101);
    @(negedge clk);
    start_a = 1'b0;
    wait_strobe_a(3);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'(0));
    chk("abort_sser", 32'(bus_a.sser), 32'(1));
    chk("abort_ba13", 32'(bus_a.ba13), 32'(1));
    chk("abort_ba12", 32'(bus_a.ba12), 32'(0));
    chk("abort_nib", 32'(bus_a.ba_nib), 32'(0));
    chk("abort_rsp", 32'(rsp_a), 32'(4'b0001));
    chk("abort_pass", 32'(pass_a), 32'(0));
    repeat (30) @(negedge clk);

    // Start while busy is ignored; start with abort in IDLE is dropped
    push_nibs(16'h3A25, 4);
    start_run_a(16'h3A25, 4'b1101);
    sb_a.push_back('{rsp: 32'(4'b1101), pass: 1'b1, st: cyc, lat: 32'd17});
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    seq_a   = 16'hFFFF;
    exp_a   = 4'h0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_idle_a();
    seq_a   = 16'h3A25;
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("start_abort_busy", 32'(busy_a), 32'(0));
    chk("start_abort_sser", 32'(bus_a.sser), 32'(1));
    chk("idle_abort_rsp", 32'(rsp_a), 32'(4'b1101));
    chk("idle_abort_pass", 32'(pass_a), 32'(1));
    repeat (3) @(negedge clk);
    chk("start_abort_busy_later", 32'(busy_a), 32'(0));

    // Second response line alone, NSTEP=2
    @(negedge clk);
    seq_b   = 8'h4C;
    exp_b   = 2'b11;
    start_b = 1'b1;
    sb_b.push_back('{rsp: 32'(2'b11), pass: 1'b1, st: cyc, lat: 32'd7});
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_b.size() == 0 && !busy_b) break;
    end
    repeat (3) @(negedge clk);

    chk("sb_a_drained", 32'(sb_a.size()), 32'(0));
    chk("sb_b_drained", 32'(sb_b.size()), 32'(0));
    chk("nib_a_drained", 32'(nib_a.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
